// File: rtl/siso_pkg.sv
// Shared types and constants for the two-requester serial transmit scheduler.
package siso_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    // Start bit plus gap cycle wrapped around every payload.
    localparam int unsigned FRAME_OVH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/siso_rr_arb.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the pointer.
module siso_rr_arb (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt_idx_c,
    output logic gnt_vld_c
);

    always_comb begin
        gnt_vld_c = req0 | req1;
        gnt_idx_c = (req0 && req1) ? ptr : req1;
    end

endmodule

// File: rtl/siso_tx_sched.sv
// Arbitrates two frame requesters and serialises the winner's word:
// start bit, WIDTH data bits MSB first, then a one-cycle gap with done.
module siso_tx_sched
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             sout,
    output logic             busy,
    output logic             src,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             ptr;
    logic             gnt_idx_c;
    logic             gnt_vld_c;

    siso_rr_arb u_arb (
        .req0      (req0),
        .req1      (req1),
        .ptr       (ptr),
        .gnt_idx_c (gnt_idx_c),
        .gnt_vld_c (gnt_vld_c)
    );

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            ptr   <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            sout  <= 1'b0;
            busy  <= 1'b0;
            src   <= 1'b0;
            done  <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld_c) begin
                        state <= START;
                        shreg <= gnt_idx_c ? data1 : data0;
                        src   <= gnt_idx_c;
                        // Pointer moves at grant so the other side wins the next tie.
                        ptr   <= ~gnt_idx_c;
                        ack0  <= ~gnt_idx_c;
                        ack1  <= gnt_idx_c;
                        sout  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= SHIFT;
                    sout  <= shreg[WIDTH-1];
                    shreg <= shreg << 1;
                    cnt   <= CW'(WIDTH - 1);
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        sout  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= cnt - CW'(1);
                        sout  <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    sout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/siso_tx_sched.md
SISO_TX_SCHED -- requirements
Module: siso_tx_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the payload bits per frame.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 asks for one frame; held high until ack0.
REQ-005 data0  input  WIDTH  requester 0 payload; sampled on grant.
REQ-006 req1  input  1  requester 1 request; same rules as req0.
REQ-007 data1  input  WIDTH  requester 1 payload.
REQ-008 ack0  output  1  one-cycle grant/capture acknowledge to requester 0.
REQ-009 ack1  output  1  one-cycle grant/capture acknowledge to requester 1.
REQ-010 sout  output  1  serial line out.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 src  output  1  index of the requester whose frame is on the line; valid while busy.
REQ-013 done  output  1  one-cycle pulse marking the last cycle of a frame.

Function
REQ-014 The FSM SHALL have states IDLE, START, SHIFT and GAP.
REQ-015 IDLE: sout=0 and busy=0; on a rising edge with req0 or req1 high, the block latches the winner's data into the shift register, sets src and moves to START.
REQ-016 Arbitration SHALL be round-robin between two requesters: the priority pointer favours the requester not served last; after reset it favours requester 0.
REQ-017 With only one request high, that requester SHALL win regardless of the pointer.
REQ-018 ackN SHALL be high for exactly the START cycle of a frame granted to requester N; at most one ack is high in any cycle.
REQ-019 START: sout=1 (start bit) for one cycle, then SHIFT.
REQ-020 SHIFT: WIDTH cycles, sout = shift-register MSB, left shift by one per cycle, bit counter WIDTH-1 down to 0; the cycle with count 0 is followed by GAP.
REQ-021 GAP: sout=0 for one cycle with done=1; the next state is IDLE.
REQ-022 A frame SHALL occupy exactly WIDTH+2 cycles (START, WIDTH data bits MSB first, GAP); IDLE lasts at least one cycle between frames.
REQ-023 Requests and data changes while busy SHALL be ignored; a frame in flight always uses the word captured at grant.
REQ-024 A request withdrawn before it is granted SHALL produce no ack and no frame.
REQ-025 The pointer SHALL update at grant time, not at frame end.

Reset
REQ-026 While rst=0: state=IDLE; sout, busy, src, ack0, ack1 and done = 0; shift register and bit counter = 0; pointer favours requester 0.
REQ-027 A reset mid-frame SHALL abandon the frame immediately with no done pulse; operation resumes on the first edge after rst rises.

Structure
REQ-028 Package siso_pkg SHALL hold the state enum typedef, the default WIDTH and the frame-overhead constant (2).
REQ-029 Round-robin selection SHALL be a sub-module siso_rr_arb (inputs req0/req1 and pointer; outputs grant index and grant valid); the FSM, shift register and counter stay in siso_tx_sched.

Verification (WIDTH=8)
REQ-030 After reset release, pulse req0 with data0=8'hA5 held until ack0 -> ack0 one cycle; sout = 1,1,0,1,0,0,1,0,1,0; done in the 10th cycle; src=0.
REQ-031 req0 (8'h0F) and req1 (8'hF0) raised together after reset -> requester 0 frame first, then one IDLE cycle, then requester 1 frame; src 0 then 1.
REQ-032 req0 and req1 held high continuously for 4 frames -> grants alternate 0,1,0,1; every frame is 10 cycles with one IDLE cycle between frames.
REQ-033 rst driven low during the 4th data bit of a frame -> sout, busy, ack and done go to 0 immediately with no done pulse; after release a req1-only request is granted and the pointer favours 0.
REQ-034 req1 pulsed and dropped while busy, and data0 changed after ack0 -> no ack1; the transmitted word equals the value captured at ack0.
